ysyx_25030077_fetch_seq: RTL and testbench
==========================================

// Module: ysyx_25030077_fetch_seq
// PURPOSE
//  Multi-cycle instruction sequencer. Owns the PC and instruction registers.
//  Fetches each instruction over a valid/ready instruction-memory port and presents pc/instruction to the
//  next-PC unit and execute stage. Commits io_pc_next when execute completes, and halts on fault.
//  Sits between the imem bus and the PC_next/decode/execute datapath.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC value loaded at reset
//  TIMEOUT   16             max WAIT cycles for an imem response before halting (>=2)
// PORTS
//  clock                      in  1   single clock, rising edge
//  reset                      in  1   asynchronous, active-low (0 = in reset)
//  io_start                   in  1   leave IDLE and begin fetching
//  io_imem_req_valid          out 1   fetch request valid
//  io_imem_req_ready          in  1   memory accepts request
//  io_imem_req_addr           out 32  fetch address (= io_pc_count)
//  io_imem_resp_valid         in  1   response valid (single cycle, no backpressure)
//  io_imem_resp_data          in  32  fetched instruction
//  io_imem_resp_err           in  1   bus error, qualified by resp_valid
//  io_pc_count                out 32  current PC register
//  io_instruction             out 32  instruction register
//  io_pc_next                 in  32  next PC from PC_next unit
//  io_is_unknown_instruction  in  1   PC_next/decode flags illegal type
//  io_exec_valid              out 1   instruction in IR is being executed
//  io_exec_done               in  1   execute/writeback complete
//  io_halt                    out 1   sequencer stopped (sticky)
//  io_halt_cause              out 3   0 none,1 illegal,2 bus err,3 timeout,4 misaligned target
//  io_retired                 out 32  retired-instruction count, wraps
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=32'h0000_0013, tmo=0, retired=0, halt=0,
//   cause=0, req_valid=0, exec_valid=0. Reset mid-operation aborts everything; nothing is retained.
//  States: IDLE, FETCH, WAIT, EXEC, HALT. All outputs are registered or decoded from state only.
//  IDLE: outputs idle; io_start=1 -> FETCH.
//  FETCH: req_valid=1, req_addr=pc. Valid/addr held stable until req_ready. valid&ready -> WAIT, tmo=0.
//  WAIT: response accepted from the cycle after the handshake. tmo increments each WAIT cycle.
//   resp_valid&err -> HALT cause 2. resp_valid&!err -> ir<=resp_data, EXEC.
//   No resp and tmo==TIMEOUT-1 -> HALT cause 3. resp_valid in same cycle as timeout: response wins.
//  EXEC: exec_valid=1. io_exec_done may be high in the first EXEC cycle.
//   unknown=1 -> HALT cause 1; pc/retired unchanged; unknown has priority over done.
//   else done=1 -> pc<=io_pc_next, retired<=retired+1 (mod 2^32).
//    If io_pc_next[1:0]!=0, go to HALT cause 4 (pc holds the faulting target); otherwise go to FETCH.
//   io_pc_next==pc (self-loop type) is legal and simply refetches the same address.
//  HALT: sticky until reset. All handshake outputs stay 0; pc/ir/retired are frozen; io_halt=1.
//  imem responses arriving outside WAIT are ignored. io_start is ignored outside IDLE.
//  Best-case throughput: 3 cycles/instruction (FETCH ready, resp next cycle, done in first EXEC cycle).
// TESTING
//  1. reset, start, ready=1, resp 1 cycle after accept (0x00000013), pc_next=pc+4, done immediate
//     -> req addrs 0x80000000, 0x80000004, ... every 3 cycles; retired=2 after 2nd EXEC.
//  2. req_ready held 0 for 5 cycles -> req_valid=1 and req_addr constant for all 5; state stays FETCH.
//  3. resp_valid=1, resp_err=1 -> next cycle halt=1, cause=2; req_valid=0 forever; retired unchanged.
//  4. TIMEOUT=16, no response -> halt cause 3 after 16th WAIT cycle.
//     Rerun with resp on that cycle -> EXEC, no halt.
//  5. EXEC with unknown=1 and done=1 -> halt cause 1, pc and retired unchanged.
//     Then pc_next=0x80000102 on a fresh run -> pc=0x80000102, retired+1, halt cause 4.
//  6. reset deasserted->asserted during WAIT, resp arrives after reset release
//     -> outputs at reset values, resp ignored, IDLE until io_start.

Source files
------------

// File: rtl/ysyx_25030077_fetch_seq.sv
// ysyx_25030077_fetch_seq: multi-cycle fetch/execute sequencer owning PC and IR.
// Handshake outputs are decoded from the state register; everything else is registered.
module ysyx_25030077_fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_start,
   output logic        io_imem_req_valid,
   input  logic        io_imem_req_ready,
   output logic [31:0] io_imem_req_addr,
   input  logic        io_imem_resp_valid,
   input  logic [31:0] io_imem_resp_data,
   input  logic        io_imem_resp_err,
   output logic [31:0] io_pc_count,
   output logic [31:0] io_instruction,
   input  logic [31:0] io_pc_next,
   input  logic        io_is_unknown_instruction,
   output logic        io_exec_valid,
   input  logic        io_exec_done,
   output logic        io_halt,
   output logic [2:0]  io_halt_cause,
   output logic [31:0] io_retired
);
   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;
   state_t        state_q;
   logic [31:0]   pc_q, ir_q, retired_q;
   logic [TW-1:0] tmo_q;
   logic [2:0]    cause_q;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= 32'h0000_0013;
         retired_q <= '0;
         tmo_q     <= '0;
         cause_q   <= 3'd0;
      end else begin
         case (state_q)
            S_IDLE: if (io_start) state_q <= S_FETCH;
            S_FETCH: if (io_imem_req_ready) begin
               state_q <= S_WAIT;
               tmo_q   <= '0;
            end
            S_WAIT: begin
               tmo_q <= tmo_q + 1'b1;
               // a response in the final timeout cycle still wins
               if (io_imem_resp_valid && io_imem_resp_err) begin
                  state_q <= S_HALT;
                  cause_q <= 3'd2;
               end else if (io_imem_resp_valid) begin
                  ir_q    <= io_imem_resp_data;
                  state_q <= S_EXEC;
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= S_HALT;
                  cause_q <= 3'd3;
               end
            end
            S_EXEC: if (io_is_unknown_instruction) begin
               state_q <= S_HALT;
               cause_q <= 3'd1;
            end else if (io_exec_done) begin
               pc_q      <= io_pc_next;
               retired_q <= retired_q + 32'd1;
               state_q   <= (io_pc_next[1:0] != 2'b00) ? S_HALT : S_FETCH;
               cause_q   <= (io_pc_next[1:0] != 2'b00) ? 3'd4 : 3'd0;
            end
            default: ;
         endcase
      end
   end
   assign io_imem_req_valid = (state_q == S_FETCH);
   assign io_imem_req_addr  = pc_q;
   assign io_exec_valid     = (state_q == S_EXEC);
   assign io_halt           = (state_q == S_HALT);
   assign io_halt_cause     = cause_q;
   assign io_pc_count       = pc_q;
   assign io_instruction    = ir_q;
   assign io_retired        = retired_q;
endmodule

// File: tb/tb_ysyx_25030077_fetch_seq.sv
// tb_ysyx_25030077_fetch_seq: directed and randomized checks of the fetch sequencer
// against a per-instruction model of pc, ir and retired count.
module tb_ysyx_25030077_fetch_seq;
   localparam logic [31:0] RPC = 32'h8000_0000;
   localparam int TMO = 16;
   logic        clock = 1'b0, reset = 1'b1, io_start = 1'b0;
   logic        io_imem_req_ready = 1'b0, io_imem_resp_valid = 1'b0, io_imem_resp_err = 1'b0;
   logic [31:0] io_imem_resp_data = '0, io_pc_next = '0;
   logic        io_is_unknown_instruction = 1'b0, io_exec_done = 1'b0;
   logic        io_imem_req_valid, io_exec_valid, io_halt;
   logic [31:0] io_imem_req_addr, io_pc_count, io_instruction, io_retired;
   logic [2:0]  io_halt_cause;
   int          checks = 0, failures = 0;
   logic [31:0] m_pc, m_ir, m_ret, tmp, nxt;

   ysyx_25030077_fetch_seq #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .io_start(io_start),
      .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
      .io_imem_req_addr(io_imem_req_addr), .io_imem_resp_valid(io_imem_resp_valid),
      .io_imem_resp_data(io_imem_resp_data), .io_imem_resp_err(io_imem_resp_err),
      .io_pc_count(io_pc_count), .io_instruction(io_instruction), .io_pc_next(io_pc_next),
      .io_is_unknown_instruction(io_is_unknown_instruction), .io_exec_valid(io_exec_valid),
      .io_exec_done(io_exec_done), .io_halt(io_halt), .io_halt_cause(io_halt_cause),
      .io_retired(io_retired)
   );

   always #5 clock = ~clock;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      io_start = 1'b0; io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'b0;
      io_imem_resp_err = 1'b0; io_is_unknown_instruction = 1'b0; io_exec_done = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk32({tag, "_pc"}, io_pc_count, RPC);
      chk32({tag, "_ir"}, io_instruction, 32'h0000_0013);
      chk32({tag, "_ret"}, io_retired, 32'd0);
      chk1({tag, "_halt"}, io_halt, 1'b0);
      chk32({tag, "_cause"}, {29'd0, io_halt_cause}, 32'd0);
      chk1({tag, "_reqv"}, io_imem_req_valid, 1'b0);
      chk1({tag, "_exv"}, io_exec_valid, 1'b0);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      #2;
      check_reset_vals("rst");
      m_pc = RPC; m_ir = 32'h0000_0013; m_ret = 32'd0;
      tick();
      reset = 1'b1;
      tick();
      chk1("idle_reqv", io_imem_req_valid, 1'b0);
   endtask

   task automatic start_run();
      io_start = 1'b1;
      tick();
      io_start = 1'b0;
      chk1("start_reqv", io_imem_req_valid, 1'b1);
      chk32("start_addr", io_imem_req_addr, m_pc);
   endtask

   // FETCH with rd stalled cycles (stray responses and io_start must be ignored), ends in WAIT
   task automatic do_fetch(input int rd);
      for (int i = 0; i < rd; i++) begin
         io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'($urandom);
         io_imem_resp_err = 1'($urandom); io_imem_resp_data = $urandom; io_start = 1'($urandom);
         tick();
         chk1("fetch_hold_v", io_imem_req_valid, 1'b1);
         chk32("fetch_hold_a", io_imem_req_addr, m_pc);
      end
      io_imem_req_ready = 1'b1;
      tick();
      clear_inputs();
      chk1("wait_reqv", io_imem_req_valid, 1'b0);
      chk32("wait_ir", io_instruction, m_ir);
   endtask

   // response arrives on WAIT cycle rd+1, ends in EXEC
   task automatic do_resp(input int rd, input logic [31:0] d);
      for (int i = 0; i < rd; i++) begin
         tick();
         chk1("wait_nohalt", io_halt, 1'b0);
         chk1("wait_exv", io_exec_valid, 1'b0);
      end
      io_imem_resp_valid = 1'b1; io_imem_resp_data = d;
      tick();
      io_imem_resp_valid = 1'b0; io_imem_resp_data = $urandom;
      m_ir = d;
      chk1("exec_v", io_exec_valid, 1'b1);
      chk32("exec_ir", io_instruction, m_ir);
   endtask

   task automatic do_exec(input int dd, input logic [31:0] n);
      for (int i = 0; i < dd; i++) begin
         io_pc_next = $urandom;
         tick();
         chk1("exec_hold", io_exec_valid, 1'b1);
         chk32("exec_wait_pc", io_pc_count, m_pc);
      end
      io_pc_next = n; io_exec_done = 1'b1;
      tick();
      io_exec_done = 1'b0;
      m_pc = n; m_ret = m_ret + 32'd1;
      chk32("commit_pc", io_pc_count, m_pc);
      chk32("retired", io_retired, m_ret);
      if (n[1:0] != 2'b00) begin
         chk1("mis_halt", io_halt, 1'b1);
         chk32("mis_cause", {29'd0, io_halt_cause}, 32'd4);
         chk1("mis_reqv", io_imem_req_valid, 1'b0);
      end else begin
         chk1("next_reqv", io_imem_req_valid, 1'b1);
         chk32("next_addr", io_imem_req_addr, m_pc);
         chk1("next_halt", io_halt, 1'b0);
      end
   endtask

   // HALT must ignore every input and freeze all state
   task automatic hold_halt(input logic [2:0] c);
      for (int i = 0; i < 4; i++) begin
         io_start = 1'b1; io_imem_req_ready = 1'b1; io_imem_resp_valid = 1'b1;
         io_imem_resp_data = $urandom; io_exec_done = 1'b1; io_pc_next = $urandom;
         tick();
         chk1("halt_sticky", io_halt, 1'b1);
         chk32("halt_cause", {29'd0, io_halt_cause}, {29'd0, c});
         chk1("halt_reqv", io_imem_req_valid, 1'b0);
         chk1("halt_exv", io_exec_valid, 1'b0);
         chk32("halt_pc", io_pc_count, m_pc);
         chk32("halt_ir", io_instruction, m_ir);
         chk32("halt_ret", io_retired, m_ret);
      end
      clear_inputs();
   endtask

   initial begin
      #3;
      do_reset();
      start_run();
      // back-to-back best-case instructions
      do_fetch(0); do_resp(0, 32'h0000_0013); do_exec(0, m_pc + 32'd4);
      do_fetch(0); do_resp(0, 32'h0000_0013); do_exec(0, m_pc + 32'd4);
      chk32("t1_addr", io_imem_req_addr, 32'h8000_0008);
      chk32("t1_ret", io_retired, 32'd2);
      // stalled request, delayed response, self-loop target
      do_fetch(5); do_resp(3, $urandom); do_exec(2, m_pc);
      chk32("selfloop_addr", io_imem_req_addr, 32'h8000_0008);
      // bus error
      do_fetch(1);
      io_imem_resp_valid = 1'b1; io_imem_resp_err = 1'b1; io_imem_resp_data = $urandom;
      tick();
      clear_inputs();
      chk1("err_halt", io_halt, 1'b1);
      chk32("err_cause", {29'd0, io_halt_cause}, 32'd2);
      chk32("err_ret", io_retired, m_ret);
      hold_halt(3'd2);
      // timeout after the 16th WAIT cycle
      do_reset(); start_run(); do_fetch(0);
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         chk1("tmo_early", io_halt, 1'b0);
      end
      tick();
      chk1("tmo_halt", io_halt, 1'b1);
      chk32("tmo_cause", {29'd0, io_halt_cause}, 32'd3);
      hold_halt(3'd3);
      // response on the timeout cycle wins
      do_reset(); start_run(); do_fetch(0);
      do_resp(TMO - 1, 32'hdead_beef);
      chk1("tmo_win_halt", io_halt, 1'b0);
      do_exec(0, m_pc + 32'd4);
      // unknown beats done
      do_fetch(0); do_resp(0, $urandom);
      io_pc_next = $urandom; io_is_unknown_instruction = 1'b1; io_exec_done = 1'b1;
      tick();
      clear_inputs();
      chk1("unk_halt", io_halt, 1'b1);
      chk32("unk_cause", {29'd0, io_halt_cause}, 32'd1);
      chk32("unk_pc", io_pc_count, m_pc);
      chk32("unk_ret", io_retired, m_ret);
      hold_halt(3'd1);
      // misaligned target
      do_reset(); start_run(); do_fetch(0); do_resp(0, $urandom);
      do_exec(0, 32'h8000_0102);
      chk32("mis_pc", io_pc_count, 32'h8000_0102);
      chk32("mis_ret", io_retired, 32'd1);
      hold_halt(3'd4);
      // reset during WAIT, response after release is ignored
      do_reset(); start_run();
      do_fetch(0); do_resp(0, $urandom); do_exec(0, m_pc + 32'd8);
      do_fetch(2);
      reset = 1'b0;
      #2;
      check_reset_vals("midrst");
      m_pc = RPC; m_ir = 32'h0000_0013; m_ret = 32'd0;
      tick();
      reset = 1'b1;
      io_imem_resp_valid = 1'b1; io_imem_resp_data = 32'h1234_5678;
      tick();
      io_imem_resp_valid = 1'b0;
      chk1("midrst_exv", io_exec_valid, 1'b0);
      chk32("midrst_ir", io_instruction, 32'h0000_0013);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("midrst_idle", io_imem_req_valid, 1'b0);
      end
      start_run();
      // randomized instruction stream
      for (int k = 0; k < 30; k++) begin
         do_fetch(int'($urandom_range(0, 3)));
         do_resp(int'($urandom_range(0, TMO - 1)), $urandom);
         tmp = $urandom;
         case ($urandom_range(0, 2))
            0: nxt = m_pc;
            1: nxt = m_pc + 32'd4;
            default: nxt = {tmp[31:2], 2'b00};
         endcase
         do_exec(int'($urandom_range(0, 2)), nxt);
      end
      do_fetch(0); do_resp(0, $urandom); do_exec(1, m_pc + 32'd2);
      hold_halt(3'd4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
